pipeline_sequencer: RTL and testbench

Frame-aligned sequencer for the 125 MHz processing pipeline (camera output buffer → grayscale → gaussian → sobel → frame memory). It starts camera configuration after reset and retries it on timeout. It flushes the pipeline whenever the user configuration (mode, sobel, gaussian) changes, and applies the new configuration atomically at the next camera start-of-frame. It also handles freeze requests on frame boundaries, so downstream blocks never see a partial frame under a mixed configuration.

---
 rtl/pipeline_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Frame-aligned sequencer: camera configuration bring-up with retry, pipeline
// flush on configuration change, and freeze handling on frame boundaries.
module pipeline_sequencer #(
  parameter int FLUSH_CYCLES = 16,
  parameter int CFG_TIMEOUT  = 1048576
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_mode,
  input  logic       i_sobel,
  input  logic       i_gaussian,
  input  logic       i_freeze,
  input  logic       i_sof,
  input  logic       i_cfg_done,
  output logic       o_cam_start,
  output logic       o_pipe_flush,
  output logic       o_mode,
  output logic       o_sobel_enable,
  output logic       o_gaussian_enable,
  output logic       o_frozen,
  output logic [2:0] o_state
);

  localparam int CW = (CFG_TIMEOUT > 2) ? $clog2(CFG_TIMEOUT) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(CFG_TIMEOUT - 1);
  localparam logic [CW-1:0] FLUSH_LAST   = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    CFG_WAIT = 3'd1,
    FLUSH    = 3'd2,
    WAIT_SOF = 3'd3,
    RUN      = 3'd4,
    FROZEN   = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          freeze_pending;
  logic [3:0]    sync_meta;
  logic [3:0]    sync_sw;
  logic          sw_mode;
  logic          sw_sobel;
  logic          sw_gaussian;
  logic          sw_freeze;
  logic          cfg_change;

  // Raw switches are asynchronous to CLK; two flops before any use.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_meta <= '0;
      sync_sw   <= '0;
    end else begin
      sync_meta <= {i_freeze, i_gaussian, i_sobel, i_mode};
      sync_sw   <= sync_meta;
    end
  end

  assign sw_mode     = sync_sw[0];
  assign sw_sobel    = sync_sw[1];
  assign sw_gaussian = sync_sw[2];
  assign sw_freeze   = sync_sw[3];
  assign cfg_change  = {sw_gaussian, sw_sobel, sw_mode} !=
                       {o_gaussian_enable, o_sobel_enable, o_mode};
  assign o_state     = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= INIT;
      cnt               <= '0;
      freeze_pending    <= 1'b0;
      o_cam_start       <= 1'b0;
      o_pipe_flush      <= 1'b1;
      o_mode            <= 1'b0;
      o_sobel_enable    <= 1'b0;
      o_gaussian_enable <= 1'b0;
      o_frozen          <= 1'b0;
    end else begin
      o_cam_start <= 1'b0;
      cnt         <= (cnt == '1) ? cnt : cnt + 1'b1;

      case (state)
        // After reset the start pulse is raised here; on a retry it was
        // already raised together with the transition back into INIT.
        INIT: begin
          if (!o_cam_start) begin
            o_cam_start <= 1'b1;
          end else begin
            state <= CFG_WAIT;
            cnt   <= '0;
          end
        end

        CFG_WAIT: begin
          if (i_cfg_done) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= INIT;
            o_cam_start <= 1'b1;
            cnt         <= '0;
          end
        end

        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state <= WAIT_SOF;
            cnt   <= '0;
          end
        end

        // New configuration becomes active exactly on a frame boundary.
        WAIT_SOF: begin
          if (i_sof) begin
            state             <= RUN;
            cnt               <= '0;
            o_mode            <= sw_mode;
            o_sobel_enable    <= sw_sobel;
            o_gaussian_enable <= sw_gaussian;
            freeze_pending    <= 1'b0;
            o_pipe_flush      <= 1'b0;
          end
        end

        // A configuration change wins over a pending freeze on the same SOF.
        RUN: begin
          if (cfg_change) begin
            state        <= FLUSH;
            cnt          <= '0;
            o_pipe_flush <= 1'b1;
          end else begin
            freeze_pending <= sw_freeze;
            if ((sw_freeze || freeze_pending) && i_sof) begin
              state        <= FROZEN;
              cnt          <= '0;
              o_pipe_flush <= 1'b1;
              o_frozen     <= 1'b1;
            end
          end
        end

        FROZEN: begin
          if (!sw_freeze) begin
            state          <= FLUSH;
            cnt            <= '0;
            o_frozen       <= 1'b0;
            freeze_pending <= 1'b0;
          end
        end

        default: begin
          state        <= INIT;
          cnt          <= '0;
          o_pipe_flush <= 1'b1;
          o_frozen     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: bring-up, config change flush,
// freeze, change-versus-freeze priority, reset mid-flush and config retry.
module tb_pipeline_sequencer;

  localparam int FLUSH_CYCLES = 16;
  localparam int CFG_TIMEOUT  = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic       sof = 1'b0;
  logic       cfgDone = 1'b1;
  logic       camStart;
  logic       pipeFlush;
  logic       modeOut;
  logic       sobelOut;
  logic       gaussianOut;
  logic       frozenOut;
  logic [2:0] stateOut;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int camPulses = 0;
  int flushCount;
  int pulseCycle[$];

  pipeline_sequencer #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CFG_TIMEOUT (CFG_TIMEOUT)
  ) dut (
    .CLK              (clock),
    .RST              (reset),
    .i_mode           (sw[0]),
    .i_sobel          (sw[1]),
    .i_gaussian       (sw[2]),
    .i_freeze         (sw[3]),
    .i_sof            (sof),
    .i_cfg_done       (cfgDone),
    .o_cam_start      (camStart),
    .o_pipe_flush     (pipeFlush),
    .o_mode           (modeOut),
    .o_sobel_enable   (sobelOut),
    .o_gaussian_enable(gaussianOut),
    .o_frozen         (frozenOut),
    .o_state          (stateOut)
  );

  always #4 clock = ~clock;

  task checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // sw = {freeze, gaussian, sobel, mode}; one clock per call
  task applyStimulus(input logic [3:0] swIn, input logic sofIn, input logic cfgIn);
    sw = swIn;
    sof = sofIn;
    cfgDone = cfgIn;
    @(posedge clock);
    #1;
    cycle++;
    if (camStart) begin
      camPulses++;
      pulseCycle.push_back(cycle);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_state", 32'(stateOut), 0);
    checkOutput("rst_cam_start", 32'(camStart), 0);
    checkOutput("rst_flush", 32'(pipeFlush), 1);
    checkOutput("rst_mode", 32'(modeOut), 0);
    checkOutput("rst_frozen", 32'(frozenOut), 0);
    reset = 1'b0;

    // bring-up with cfg_done already high
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("init_state", 32'(stateOut), 0);
    checkOutput("init_cam_start", 32'(camStart), 1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("cfgwait_state", 32'(stateOut), 1);
    checkOutput("cfgwait_cam_start", 32'(camStart), 0);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("flush_entry", 32'(stateOut), 2);
    flushCount = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0000, 1'b0, 1'b1);
      if (stateOut == 3'd2) flushCount++;
      else break;
    end
    checkOutput("flush_len", flushCount, 16);
    checkOutput("waitsof_state", 32'(stateOut), 3);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("waitsof_hold", 32'(stateOut), 3);
    checkOutput("waitsof_flush", 32'(pipeFlush), 1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("run_state", 32'(stateOut), 4);
    checkOutput("run_flush", 32'(pipeFlush), 0);
    checkOutput("bringup_pulses", camPulses, 1);

    // sobel change: FLUSH three cycles later, SOF during FLUSH ignored
    applyStimulus(4'b0010, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    checkOutput("sobel_latency_run", 32'(stateOut), 4);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    checkOutput("sobel_flush_state", 32'(stateOut), 2);
    checkOutput("sobel_flush_out", 32'(pipeFlush), 1);
    for (int i = 0; i < 15; i++) applyStimulus(4'b0010, (i == 5), 1'b1);
    checkOutput("sof_in_flush", 32'(stateOut), 2);
    checkOutput("sobel_not_yet", 32'(sobelOut), 0);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    checkOutput("sobel_waitsof", 32'(stateOut), 3);
    applyStimulus(4'b0010, 1'b1, 1'b1);
    checkOutput("sobel_run", 32'(stateOut), 4);
    checkOutput("sobel_latched", 32'(sobelOut), 1);
    checkOutput("sobel_flush_low", 32'(pipeFlush), 0);

    // freeze on next SOF, gaussian ignored while frozen
    repeat (3) applyStimulus(4'b1010, 1'b0, 1'b1);
    checkOutput("freeze_wait_sof", 32'(stateOut), 4);
    applyStimulus(4'b1010, 1'b1, 1'b1);
    checkOutput("frozen_state", 32'(stateOut), 5);
    checkOutput("frozen_out", 32'(frozenOut), 1);
    checkOutput("frozen_flush", 32'(pipeFlush), 1);
    repeat (5) applyStimulus(4'b1110, 1'b0, 1'b1);
    checkOutput("frozen_hold", 32'(stateOut), 5);
    checkOutput("frozen_gauss", 32'(gaussianOut), 0);
    repeat (3) applyStimulus(4'b0110, 1'b0, 1'b1);
    checkOutput("unfreeze_flush", 32'(stateOut), 2);
    checkOutput("unfreeze_frozen", 32'(frozenOut), 0);
    repeat (15) applyStimulus(4'b0110, 1'b0, 1'b1);
    applyStimulus(4'b0110, 1'b0, 1'b1);
    checkOutput("unfreeze_waitsof", 32'(stateOut), 3);
    applyStimulus(4'b0110, 1'b1, 1'b1);
    checkOutput("unfreeze_run", 32'(stateOut), 4);
    checkOutput("gauss_latched", 32'(gaussianOut), 1);
    checkOutput("sobel_kept", 32'(sobelOut), 1);

    // mode change and SOF together with freeze pending: FLUSH wins
    repeat (3) applyStimulus(4'b1110, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("prio_pre_run", 32'(stateOut), 4);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("prio_flush", 32'(stateOut), 2);
    checkOutput("prio_not_frozen", 32'(frozenOut), 0);

    // reset mid-FLUSH acts immediately
    repeat (5) applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("midflush_state", 32'(stateOut), 2);
    sw = 4'b0000;
    sof = 1'b0;
    cfgDone = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_state", 32'(stateOut), 0);
    checkOutput("async_rst_flush", 32'(pipeFlush), 1);
    checkOutput("async_rst_sobel", 32'(sobelOut), 0);
    checkOutput("async_rst_gauss", 32'(gaussianOut), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    camPulses = 0;
    cycle = 0;
    pulseCycle.delete();

    // cfg_done held low: start pulse repeats every CFG_TIMEOUT+1 cycles
    repeat (200) applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("retry_pulses", camPulses, 4);
    checkOutput("retry_first", (pulseCycle.size() > 0) ? pulseCycle[0] : -1, 1);
    checkOutput("retry_period1", (pulseCycle.size() > 1) ? pulseCycle[1] - pulseCycle[0] : -1, 65);
    checkOutput("retry_period2", (pulseCycle.size() > 2) ? pulseCycle[2] - pulseCycle[1] : -1, 65);
    checkOutput("retry_cfgwait", 32'(stateOut), 1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("cfgdone_flush", 32'(stateOut), 2);
    repeat (15) applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("cfgdrop_flush", 32'(stateOut), 2);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("cfgdrop_waitsof", 32'(stateOut), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
